// File: rtl/calc_entry_fsm.sv
// calc_entry_fsm
//
// Sequencer for keypad calculator entry and arithmetic. It takes one-cycle key
// events from the keypad decoder and uses them to:
//   - build up two multi-digit decimal operands,
//   - latch the operator,
//   - compute a signed result on '='.
// It also drives the registered value that the display driver shows.
//
// Ports:
//   clk            system clock, rising edge
//   reset          asynchronous, active-low reset
//   key_valid      one-cycle strobe qualifying key_code
//   key_code[3:0]  0-9 digit, 10 '+', 11 '-', 12 '*', 13 clear, 14 '=', 15 ignored
//   key_ready      high whenever a key will be accepted (low only in EXEC)
//   display_value  registered signed value for the display
//   result_valid   one-cycle pulse when a new result is registered
//   error          high while the result has overflowed (ERR state)
//   state[2:0]     current FSM state encoding, for debug
module calc_entry_fsm #(
  parameter int DATA_W     = 32,
  parameter int MAX_DIGITS = 4,
  parameter int MAX_MAG    = 99_999_999
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     key_valid,
  input  logic [3:0]               key_code,
  output logic                     key_ready,
  output logic signed [DATA_W-1:0] display_value,
  output logic                     result_valid,
  output logic                     error,
  output logic [2:0]               state
);

  typedef enum logic [2:0] {
    S_FIRST  = 3'd0,
    S_OP     = 3'd1,
    S_SECOND = 3'd2,
    S_EXEC   = 3'd3,
    S_RESULT = 3'd4,
    S_ERR    = 3'd5
  } state_e;

  localparam int WIDE_W = 2 * DATA_W;
  localparam logic signed [DATA_W-1:0] TEN       = DATA_W'(10);
  localparam logic signed [WIDE_W-1:0] MAX_MAG_W = WIDE_W'(MAX_MAG);
  localparam logic signed [WIDE_W-1:0] MIN_MAG_W = -MAX_MAG_W;

  // Operator select encoding: 0 add, 1 subtract, 2 multiply.
  function automatic logic [1:0] op_of(input logic [3:0] k);
    case (k)
      4'd11:   return 2'd1;
      4'd12:   return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

  state_e                    state_q, state_d;
  logic signed [DATA_W-1:0]  op_a_q, op_a_d;
  logic signed [DATA_W-1:0]  op_b_q, op_b_d;
  logic signed [DATA_W-1:0]  result_q, result_d;
  logic signed [DATA_W-1:0]  display_q, display_d;
  logic [1:0]                op_sel_q, op_sel_d;
  logic [2:0]                digit_cnt_q, digit_cnt_d;
  logic                      result_valid_q, result_valid_d;

  logic                      accept;
  logic                      is_digit, is_op, is_clear, is_eq;
  logic                      room_for_digit;
  logic signed [DATA_W-1:0]  digit_val;
  logic signed [WIDE_W-1:0]  a_w, b_w, calc_w;
  logic                      overflow;

  assign key_ready = (state_q != S_EXEC);
  assign accept    = key_valid && key_ready;

  assign is_digit = (key_code <= 4'd9);
  assign is_op    = (key_code == 4'd10) || (key_code == 4'd11) || (key_code == 4'd12);
  assign is_clear = (key_code == 4'd13);
  assign is_eq    = (key_code == 4'd14);

  assign digit_val      = signed'({{(DATA_W-4){1'b0}}, key_code});
  assign room_for_digit = (int'(digit_cnt_q) < MAX_DIGITS);

  // Arithmetic is done at double width so that the overflow test sees the
  // true value, not one that has wrapped in DATA_W bits.
  assign a_w = {{DATA_W{op_a_q[DATA_W-1]}}, op_a_q};
  assign b_w = {{DATA_W{op_b_q[DATA_W-1]}}, op_b_q};

  always_comb begin
    case (op_sel_q)
      2'd0:    calc_w = a_w + b_w;
      2'd1:    calc_w = a_w - b_w;
      default: calc_w = a_w * b_w;
    endcase
  end

  assign overflow = (calc_w > MAX_MAG_W) || (calc_w < MIN_MAG_W);

  always_comb begin
    state_d        = state_q;
    op_a_d         = op_a_q;
    op_b_d         = op_b_q;
    result_d       = result_q;
    op_sel_d       = op_sel_q;
    digit_cnt_d    = digit_cnt_q;
    result_valid_d = 1'b0;
    display_d      = display_q;

    // Clear can only be accepted outside EXEC, and it means the same thing
    // in every state that can accept it.
    if (accept && is_clear) begin
      state_d     = S_FIRST;
      op_a_d      = '0;
      op_b_d      = '0;
      result_d    = '0;
      op_sel_d    = '0;
      digit_cnt_d = '0;
    end else begin
      case (state_q)
        S_FIRST: begin
          if (accept && is_digit) begin
            if (room_for_digit) begin
              op_a_d      = op_a_q * TEN + digit_val;
              digit_cnt_d = digit_cnt_q + 3'd1;
            end
          end else if (accept && is_op) begin
            op_sel_d = op_of(key_code);
            state_d  = S_OP;
          end
        end
        S_OP: begin
          if (accept && is_digit) begin
            op_b_d      = digit_val;
            digit_cnt_d = 3'd1;
            state_d     = S_SECOND;
          end else if (accept && is_op) begin
            op_sel_d = op_of(key_code);
          end
        end
        S_SECOND: begin
          if (accept && is_digit) begin
            if (room_for_digit) begin
              op_b_d      = op_b_q * TEN + digit_val;
              digit_cnt_d = digit_cnt_q + 3'd1;
            end
          end else if (accept && is_eq) begin
            state_d = S_EXEC;
          end
        end
        S_EXEC: begin
          if (overflow) begin
            state_d = S_ERR;
          end else begin
            result_d       = signed'(calc_w[DATA_W-1:0]);
            result_valid_d = 1'b1;
            state_d        = S_RESULT;
          end
        end
        S_RESULT: begin
          if (accept && is_digit) begin
            op_a_d      = digit_val;
            digit_cnt_d = 3'd1;
            state_d     = S_FIRST;
          end else if (accept && is_op) begin
            op_a_d   = result_q;
            op_sel_d = op_of(key_code);
            state_d  = S_OP;
          end
        end
        default: ; // ERR: only clear leaves, and clear is handled above
      endcase
    end

    // The display register follows the state being entered, so it changes
    // in the same cycle as the operands and the result.
    case (state_d)
      S_FIRST, S_OP: display_d = op_a_d;
      S_SECOND:      display_d = op_b_d;
      S_RESULT:      display_d = result_d;
      S_EXEC:        display_d = display_q;
      default:       display_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= S_FIRST;
      op_a_q         <= '0;
      op_b_q         <= '0;
      result_q       <= '0;
      op_sel_q       <= '0;
      digit_cnt_q    <= '0;
      result_valid_q <= 1'b0;
      display_q      <= '0;
    end else begin
      state_q        <= state_d;
      op_a_q         <= op_a_d;
      op_b_q         <= op_b_d;
      result_q       <= result_d;
      op_sel_q       <= op_sel_d;
      digit_cnt_q    <= digit_cnt_d;
      result_valid_q <= result_valid_d;
      display_q      <= display_d;
    end
  end

  assign display_value = display_q;
  assign result_valid  = result_valid_q;
  assign error         = (state_q == S_ERR);
  assign state         = state_q;

endmodule
